// File: rtl/scroll_window_select.sv
// W-digit display window over an N-digit character buffer: cursor-follow, home and marquee.
// Optional end-of-scroll dwell enabled with `define MARQUEE_PAUSE_EN.
module scroll_window_select #(
   parameter int DIGIT_W     = 4,
   parameter int NUM_DIGITS  = 21,
   parameter int WIN_DIGITS  = 8,
   parameter int IDX_W       = 5,
   parameter int PAUSE_TICKS = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_DIGITS*DIGIT_W-1:0] buf_in,
   input  logic [IDX_W-1:0]              cursor,
   input  logic                          edit_en,
   input  logic                          auto_en,
   input  logic                          tick,
   output logic [WIN_DIGITS*DIGIT_W-1:0] win_out,
   output logic [IDX_W-1:0]              win_base,
   output logic [IDX_W-1:0]              cursor_rel,
   output logic                          cursor_vis
);

   localparam int WOUT   = WIN_DIGITS * DIGIT_W;
   localparam int HOME_I = NUM_DIGITS - WIN_DIGITS;

   localparam logic [IDX_W-1:0] HOME_B = IDX_W'(HOME_I);
   localparam logic [IDX_W:0]   LAST_X = (IDX_W+1)'(NUM_DIGITS - 1);
   localparam logic [IDX_W:0]   SPAN_X = (IDX_W+1)'(WIN_DIGITS - 1);

   if (WIN_DIGITS < 1 || WIN_DIGITS > NUM_DIGITS) begin : g_bad_win
      $error("scroll_window_select: WIN_DIGITS out of range");
   end
   if ((2 ** IDX_W) < NUM_DIGITS) begin : g_bad_idx
      $error("scroll_window_select: IDX_W too narrow");
   end
   if (PAUSE_TICKS < 0) begin : g_bad_pause
      $error("scroll_window_select: PAUSE_TICKS negative");
   end

   typedef enum logic [1:0] {
      ST_HOME,
      ST_FOLLOW,
      ST_MARQUEE
   } state_t;

   state_t state_q, state_d;

   logic [IDX_W-1:0] base_q, base_d;
   logic [IDX_W-1:0] rel_q, rel_d;
   logic [WOUT-1:0]  win_q, win_d;

   logic [IDX_W:0] base_x;
   logic [IDX_W:0] cur_x;
   logic [IDX_W:0] c_x;
   logic [IDX_W:0] hi_x;
   logic           move_ok;

   // edit_en wins over auto_en, so priority rather than unique.
   always_comb begin
      state_d = ST_HOME;
      priority case (1'b1)
         edit_en: state_d = ST_FOLLOW;
         auto_en: state_d = ST_MARQUEE;
         default: state_d = ST_HOME;
      endcase
   end

`ifdef MARQUEE_PAUSE_EN
   localparam int CNT_W = (PAUSE_TICKS < 1) ? 1 : $clog2(PAUSE_TICKS + 1);
   localparam logic [CNT_W-1:0] PAUSE_C = CNT_W'(PAUSE_TICKS);

   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_cur;
   logic             at_end;
   logic             dwell;

   // Count held ticks at either end of the scroll range.
   always_comb begin
      cnt_cur = (state_q == ST_MARQUEE) ? cnt_q : '0;
      at_end  = (base_q == '0) || (base_q == HOME_B);
      dwell   = at_end && (cnt_cur < PAUSE_C);
      move_ok = !dwell;
      cnt_d   = cnt_cur;
      if (state_d != ST_MARQUEE) begin
         cnt_d = '0;
      end else if (tick) begin
         if (dwell) begin
            cnt_d = cnt_cur + CNT_W'(1);
         end else begin
            cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign move_ok = 1'b1;
`endif

   always_comb begin
      base_x = {1'b0, base_q};
      cur_x  = {1'b0, cursor};
      c_x    = (cur_x > LAST_X) ? LAST_X : cur_x;
      hi_x   = base_x + SPAN_X;
      base_d = base_q;
      unique case (state_d)
         ST_FOLLOW: begin
            if (c_x > hi_x) begin
               base_d = IDX_W'(c_x - SPAN_X);
            end else if (c_x < base_x) begin
               base_d = IDX_W'(c_x);
            end else begin
               base_d = base_q;
            end
         end
         ST_MARQUEE: begin
            if (tick && move_ok) begin
               base_d = (base_q < HOME_B) ? base_q + IDX_W'(1) : '0;
            end
         end
         default: base_d = HOME_B;
      endcase
   end

   // Window slice is taken from the buffer presented this cycle.
   always_comb begin
      rel_d = '0;
      if (state_d == ST_FOLLOW) begin
         rel_d = IDX_W'(c_x - {1'b0, base_d});
      end
      win_d = WOUT'(buf_in >> (int'(base_d) * DIGIT_W));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_HOME;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q <= HOME_B;
         rel_q  <= '0;
         win_q  <= '0;
      end else begin
         base_q <= base_d;
         rel_q  <= rel_d;
         win_q  <= win_d;
      end
   end

   assign win_out    = win_q;
   assign win_base   = base_q;
   assign cursor_rel = rel_q;
   assign cursor_vis = (state_q == ST_FOLLOW);

endmodule
